bank_store_ctrl: RTL and testbench
==================================

Name: bank_store_ctrl

Overview:
- Synchronous controller and storage for a 4-entry x 8-bit register bank, written from switches (data_in, sel) on a store button press.
- Synchronizes and debounces the raw store and clear buttons.
- Issues exactly one write per debounced press and acknowledges it.
- Time-multiplexes the four entries onto a single scan output for a display driver.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synced cycles required for press and release (board build: 1000000).
- SCAN_CYCLES, 8, clock cycles each entry is presented on scan_data before advancing.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- data_in  in  8  byte to store
- sel  in  2  target entry index
- store_btn  in  1  raw asynchronous store button (btnC)
- clear_btn  in  1  raw asynchronous clear button
- bank_out0..bank_out3  out  8 each  registered entry contents
- valid  out  4  bit i set once entry i has been written since reset/clear
- store_ack  out  1  one-cycle pulse, high in the first cycle the new value is visible
- busy  out  1  high when FSM is not IDLE
- scan_idx  out  2  entry currently presented
- scan_data  out  8  equals bank_out[scan_idx]

Behaviour:
- Reset (rst_n low at a rising edge):
  - All bank entries = 8'h00, valid = 4'b0000, store_ack = 0.
  - FSM = IDLE, busy = 0, scan_idx = 0, scan counter = 0.
  - Sync flops and debounce counter = 0.
  - Reset mid-press aborts the operation; no write occurs.
- Synchronization: store_btn and clear_btn each pass through a 2-flop synchronizer. The FSM sees only the synced signals.
- FSM states: IDLE, DEBOUNCE, COMMIT, WAIT_RELEASE.
  - IDLE:
    - If synced clear is high: all entries = 0 and valid = 0 at the next edge; FSM stays IDLE. Clear wins over a simultaneous store.
    - Else if synced store is high: go to DEBOUNCE with cnt = 0.
  - DEBOUNCE:
    - If synced store is low: go to IDLE. This is a glitch; no write.
    - Else if cnt == DEBOUNCE_CYCLES-1: go to COMMIT.
    - Else cnt++.
  - COMMIT (exactly 1 cycle):
    - sel and data_in are sampled in this cycle.
    - At the exiting edge: bank[sel] = data_in, valid[sel] = 1, store_ack registered high for 1 cycle.
    - Go to WAIT_RELEASE with cnt = 0.
  - WAIT_RELEASE:
    - Synced store high: cnt = 0.
    - Synced store low: cnt++.
    - When synced store is low and cnt == DEBOUNCE_CYCLES-1: go to IDLE.
    - Holding the button never causes a second write.
- Latency: counting the first edge that samples store_btn high as edge 1, store_ack is high in the cycle after edge DEBOUNCE_CYCLES+4. bank_out updates in that same cycle.
- clear_btn outside IDLE is ignored; it takes effect only once the FSM is back in IDLE, if still held.
- Rewriting an already-valid entry overwrites it; valid stays 1.
- Unselected entries hold their value across every write.
- Scan:
  - A free-running counter runs 0..SCAN_CYCLES-1.
  - On its terminal count, scan_idx increments, wrapping 3 -> 0.
  - scan_data is a combinational mux of registered entries, so a write is visible on scan_data in the same cycle as on bank_out.
  - Scanning is independent of the FSM and of clear.
- busy = (state != IDLE).
- No latches: every storage element updates only on the clk rising edge.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams IDLE=0, DEBOUNCE=1, COMMIT=2, WAIT_RELEASE=3), NUM_ENTRIES=4, ENTRY_W=8.
- One natural sub-module: btn_sync, a 2-flop synchronizer, instantiated once per button.
- Debounce counting stays in the FSM.

Test Plan:
- Reset then idle 10 cycles:
  - bank_out0..3 = 8'h00, valid = 0, busy = 0, store_ack never high.
  - scan_idx steps 0,1,2,3,0 every 8 cycles.
- data_in = 8'hA5, sel = 2, store_btn held 40 cycles:
  - store_ack high exactly once, in the cycle after edge 20.
  - bank_out2 = A5, valid = 4'b0100, other entries 0.
  - busy returns low 16 cycles after release is synced.
- store_btn pulse of 5 cycles:
  - No write, no store_ack.
  - FSM back in IDLE; busy high for at most 5 cycles.
- Write 11/22/33/44 to entries 0..3 via four presses, then assert clear_btn:
  - All entries 0 and valid = 0 by 3 cycles after clear_btn rises.
  - scan_data tracks each value while its entry is selected.
- Press with sel = 1, data 8'h3C; change data_in to 8'hFF during WAIT_RELEASE:
  - bank_out1 stays 3C.
  - A second press with sel = 1, data 8'h7E overwrites it to 7E; valid[1] stays 1.
- Deassert rst_n during DEBOUNCE (cycle 10 of press):
  - No write, all outputs at reset values the cycle after.
  - A held button after reset release yields exactly one write.

Source files
------------

// File: rtl/bank_store_ctrl_pkg.sv
// Shared types and sizes for the register-bank store controller.
package bank_store_ctrl_pkg;

  localparam int NUM_ENTRIES = 4;
  localparam int ENTRY_W     = 8;
  localparam int IDX_W       = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    COMMIT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/bank_store_ctrl_btn_sync.sv
// Two-flop synchronizer for a raw asynchronous push button.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic synced
);

  logic meta;

  // Double-register the raw input into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/bank_store_ctrl.sv
// Debounced store/clear controller for a 4 x 8-bit register bank with a
// time-multiplexed scan output for a display driver.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   IDLE         | waiting; synced clear wipes the bank, synced store starts debounce
//   DEBOUNCE     | store must stay high DEBOUNCE_CYCLES cycles, else glitch
//   COMMIT       | one cycle; sample sel/data_in, write at exit, pulse store_ack
//   WAIT_RELEASE | store must stay low DEBOUNCE_CYCLES cycles before re-arming
module bank_store_ctrl
  import bank_store_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRY_W-1:0] data_in,
  input  logic [IDX_W-1:0]   sel,
  input  logic               store_btn,
  input  logic               clear_btn,
  output logic [ENTRY_W-1:0] bank_out0,
  output logic [ENTRY_W-1:0] bank_out1,
  output logic [ENTRY_W-1:0] bank_out2,
  output logic [ENTRY_W-1:0] bank_out3,
  output logic [NUM_ENTRIES-1:0] valid,
  output logic               store_ack,
  output logic               busy,
  output logic [IDX_W-1:0]   scan_idx,
  output logic [ENTRY_W-1:0] scan_data
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [ENTRY_W-1:0] bank [NUM_ENTRIES];
  logic               store_s;
  logic               clear_s;

  btn_sync u_sync_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (store_btn),
    .synced (store_s)
  );

  btn_sync u_sync_clear (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (clear_btn),
    .synced (clear_s)
  );

  // Sequencing FSM with debounce counter, bank storage and write acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= '0;
      store_ack <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) bank[i] <= '0;
    end else begin
      store_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Clear has priority so a simultaneous store cannot slip in.
          if (clear_s) begin
            valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) bank[i] <= '0;
          end else if (store_s) begin
            state <= DEBOUNCE;
            cnt   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!store_s)            state <= IDLE;
          else if (cnt == CNT_LAST) state <= COMMIT;
          else                     cnt   <= cnt + CNT_W'(1);
        end
        COMMIT: begin
          bank[sel]  <= data_in;
          valid[sel] <= 1'b1;
          store_ack  <= 1'b1;
          state      <= WAIT_RELEASE;
          cnt        <= '0;
        end
        WAIT_RELEASE: begin
          if (store_s)              cnt   <= '0;
          else if (cnt == CNT_LAST) state <= IDLE;
          else                      cnt   <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running scan timer; advances the presented entry on terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign bank_out0 = bank[0];
  assign bank_out1 = bank[1];
  assign bank_out2 = bank[2];
  assign bank_out3 = bank[3];
  assign scan_data = bank[scan_idx];

endmodule

// File: tb/tb_bank_store_ctrl.sv
// Self-checking bench for bank_store_ctrl: scoreboard of expected writes
// popped on every store_ack, plus per-scenario timing checks.
module tb_bank_store_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic [1:0] sel;
  logic       store_btn;
  logic       clear_btn;
  logic [7:0] bank_out0, bank_out1, bank_out2, bank_out3;
  logic [3:0] valid;
  logic       store_ack;
  logic       busy;
  logic [1:0] scan_idx;
  logic [7:0] scan_data;

  int checks    = 0;
  int failures  = 0;
  int ack_count = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] model_bank [4];
  logic [3:0] model_valid;

  bank_store_ctrl #(.DEBOUNCE_CYCLES(16), .SCAN_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .sel       (sel),
    .store_btn (store_btn),
    .clear_btn (clear_btn),
    .bank_out0 (bank_out0),
    .bank_out1 (bank_out1),
    .bank_out2 (bank_out2),
    .bank_out3 (bank_out3),
    .valid     (valid),
    .store_ack (store_ack),
    .busy      (busy),
    .scan_idx  (scan_idx),
    .scan_data (scan_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bank_at(input int i);
    case (i)
      0:       return bank_out0;
      1:       return bank_out1;
      2:       return bank_out2;
      default: return bank_out3;
    endcase
  endfunction

  // Scoreboard: each ack must match the oldest expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (store_ack === 1'b1) begin
      ack_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack actual=1 required=0 t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bank_at(int'(e.idx)) !== e.data) begin
          failures++;
          $display("FAIL ack_data idx=%0d actual=%02h required=%02h", e.idx, bank_at(int'(e.idx)), e.data);
        end
        checks++;
        if (valid[e.idx] !== 1'b1) begin
          failures++;
          $display("FAIL ack_valid idx=%0d actual=%b required=1", e.idx, valid[e.idx]);
        end
        model_bank[e.idx]  = e.data;
        model_valid[e.idx] = 1'b1;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model_bank[i] = 8'h00;
    model_valid = 4'b0000;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy !== 1'b0; i++) @(negedge clk);
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual busy=%b required=0", busy);
    end
  endtask

  task automatic press(input logic [1:0] s, input logic [7:0] d, input int hold,
                       input bit expect_wr, input int chg_at, input logic [7:0] chg_d);
    sel       = s;
    data_in   = d;
    store_btn = 1'b1;
    if (expect_wr) exp_q.push_back(wr_t'{idx: s, data: d});
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == chg_at) data_in = chg_d;
    end
    store_btn = 1'b0;
    wait_idle(40);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bank_at(i) !== 8'h00) begin
        failures++;
        $display("FAIL reset_bank%0d actual=%02h required=00", i, bank_at(i));
      end
    end
    checks++;
    if (valid !== 4'b0000) begin
      failures++;
      $display("FAIL reset_valid actual=%b required=0000", valid);
    end
    checks++;
    if (store_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack actual=%b required=0", store_ack);
    end
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (scan_idx !== 2'((k / 8) % 4)) begin
        failures++;
        $display("FAIL reset_scan_idx k=%0d actual=%0d required=%0d", k, scan_idx, (k / 8) % 4);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy k=%0d actual=%b required=0", k, busy);
      end
    end
  endtask

  task automatic test_store();
    int a0;
    a0        = ack_count;
    sel       = 2'd2;
    data_in   = 8'hA5;
    store_btn = 1'b1;
    exp_q.push_back(wr_t'{idx: 2'd2, data: 8'hA5});
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 19 || i == 20 || i == 21) begin
        checks++;
        if (store_ack !== (i == 20)) begin
          failures++;
          $display("FAIL store_latency edge=%0d actual=%b required=%b", i, store_ack, (i == 20));
        end
      end
    end
    checks++;
    if (ack_count - a0 !== 1) begin
      failures++;
      $display("FAIL store_ack_once actual=%0d required=1", ack_count - a0);
    end
    store_btn = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if (j == 17 || j == 18) begin
        checks++;
        if (busy !== (j == 17)) begin
          failures++;
          $display("FAIL release_busy j=%0d actual=%b required=%b", j, busy, (j == 17));
        end
      end
    end
    checks++;
    if (valid !== 4'b0100) begin
      failures++;
      $display("FAIL store_valid actual=%b required=0100", valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bank_at(i) !== ((i == 2) ? 8'hA5 : 8'h00)) begin
        failures++;
        $display("FAIL store_bank%0d actual=%02h required=%02h", i, bank_at(i), (i == 2) ? 8'hA5 : 8'h00);
      end
    end
  endtask

  task automatic test_glitch();
    int a0;
    int busy_cycles;
    a0          = ack_count;
    busy_cycles = 0;
    sel         = 2'd0;
    data_in     = 8'hEE;
    store_btn   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
    store_btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (busy_cycles < 1 || busy_cycles > 5) begin
      failures++;
      $display("FAIL glitch_busy_cycles actual=%0d required=1..5", busy_cycles);
    end
    checks++;
    if (ack_count !== a0) begin
      failures++;
      $display("FAIL glitch_ack actual=%0d required=%0d", ack_count, a0);
    end
    checks++;
    if (bank_out0 !== 8'h00 || valid !== 4'b0100) begin
      failures++;
      $display("FAIL glitch_write actual bank0=%02h valid=%b required 00/0100", bank_out0, valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_idle actual=%b required=0", busy);
    end
  endtask

  task automatic test_clear();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) press(2'(i), vals[i], 25, 1'b1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bank_at(i) !== vals[i]) begin
        failures++;
        $display("FAIL clear_pre_bank%0d actual=%02h required=%02h", i, bank_at(i), vals[i]);
      end
    end
    checks++;
    if (valid !== 4'b1111) begin
      failures++;
      $display("FAIL clear_pre_valid actual=%b required=1111", valid);
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checks++;
      if (scan_data !== model_bank[scan_idx]) begin
        failures++;
        $display("FAIL scan_data idx=%0d actual=%02h required=%02h", scan_idx, scan_data, model_bank[scan_idx]);
      end
    end
    clear_btn = 1'b1;
    repeat (3) @(negedge clk);
    clear_model();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bank_at(i) !== 8'h00) begin
        failures++;
        $display("FAIL clear_bank%0d actual=%02h required=00", i, bank_at(i));
      end
    end
    checks++;
    if (valid !== 4'b0000) begin
      failures++;
      $display("FAIL clear_valid actual=%b required=0000", valid);
    end
    clear_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overwrite();
    press(2'd1, 8'h3C, 25, 1'b1, 22, 8'hFF);
    checks++;
    if (bank_out1 !== 8'h3C) begin
      failures++;
      $display("FAIL hold_after_commit actual=%02h required=3C", bank_out1);
    end
    press(2'd1, 8'h7E, 25, 1'b1, 0, 8'h00);
    checks++;
    if (bank_out1 !== 8'h7E) begin
      failures++;
      $display("FAIL overwrite actual=%02h required=7E", bank_out1);
    end
    checks++;
    if (valid !== 4'b0010) begin
      failures++;
      $display("FAIL overwrite_valid actual=%b required=0010", valid);
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    sel       = 2'd3;
    data_in   = 8'h99;
    store_btn = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bank_out0 !== 8'h00 || bank_out1 !== 8'h00 || bank_out2 !== 8'h00 || bank_out3 !== 8'h00) begin
      failures++;
      $display("FAIL midreset_bank actual=%02h %02h %02h %02h required=00", bank_out0, bank_out1, bank_out2, bank_out3);
    end
    checks++;
    if (valid !== 4'b0000 || busy !== 1'b0 || store_ack !== 1'b0 || scan_idx !== 2'd0) begin
      failures++;
      $display("FAIL midreset_ctrl actual valid=%b busy=%b ack=%b idx=%0d required 0", valid, busy, store_ack, scan_idx);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    a0    = ack_count;
    exp_q.push_back(wr_t'{idx: 2'd3, data: 8'h99});
    repeat (40) @(negedge clk);
    store_btn = 1'b0;
    wait_idle(40);
    checks++;
    if (ack_count - a0 !== 1) begin
      failures++;
      $display("FAIL midreset_one_write actual=%0d required=1", ack_count - a0);
    end
    checks++;
    if (bank_out3 !== 8'h99 || valid !== 4'b1000) begin
      failures++;
      $display("FAIL midreset_result actual bank3=%02h valid=%b required 99/1000", bank_out3, valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    data_in   = 8'h00;
    sel       = 2'd0;
    store_btn = 1'b0;
    clear_btn = 1'b0;
    clear_model();
    test_reset();
    test_store();
    test_glitch();
    test_clear();
    test_overwrite();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_writes actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
